fifo_rd_drain: RTL and testbench
================================

// Module: fifo_rd_drain
// PURPOSE
// - Single-clock read-side consumer for the team's FIFOs; sits on the FIFO read port in rd_clk domain.
// - On start, pops exactly `count` words, never popping while empty.
// - Checks each word against the writer pattern exp_base + k*STEP (mod 2^WIDTH).
// - Reports completion, mismatch count and first bad word; drives FIFO rd_en in place of the bench read task.
// PARAMETERS
// - WIDTH      8   data width; matches FIFO WIDTH.
// - CNT_W      16  width of count and internal word counters.
// - STEP       2   expected-pattern increment per word.
// - TO_CYCLES  64  empty-stall watchdog limit; used only with FIFO_RD_TIMEOUT_EN.
// PORTS
// - rd_clk          in   1      the only clock; all logic is rising-edge.
// - rst             in   1      asynchronous, active-low reset (0 = reset).
// - start           in   1      1-cycle request; sampled only in IDLE.
// - count           in   CNT_W  words to drain; captured with start.
// - exp_base        in   WIDTH  expected first word; captured with start.
// - empty           in   1      FIFO empty flag.
// - rd_data         in   WIDTH  FIFO read data; valid 1 cycle after an accepted rd_en.
// - rd_en           out  1      FIFO read enable.
// - busy            out  1      high in READ and DONE.
// - done            out  1      1-cycle completion pulse.
// - mismatch_cnt    out  CNT_W  compare failures this run; saturates at all-ones.
// - first_bad_idx   out  CNT_W  index k of the first failing word.
// - first_bad_data  out  WIDTH  data of the first failing word.
// - timeout         out  1      sticky watchdog flag; exists only with the macro.
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE; rd_en=0; done=0; busy=0; mismatch_cnt=0; first_bad_*=0; timeout=0; counters=0.
// - Reset mid-run: abort immediately, with rd_en low in the same instant; no done pulse.
// - FSM IDLE -> READ on start. IDLE -> DONE on start with count==0.
// - FSM READ -> DONE when rcvd==count. DONE -> IDLE unconditionally (1 cycle).
// - Capture on start: count, exp_base into exp_q; issued=rcvd=0; mismatch_cnt and first_bad_* cleared.
// - rd_en = (state==READ) & ~empty & (issued != count_q). Combinational.
// - rd_en is never high when empty=1, so FIFO rd_error is never provoked.
// - Each rd_en cycle: issued++. Also v_q <= rd_en (1-cycle data latency).
// - Cycles with v_q=1: compare rd_data against exp_q, then exp_q += STEP (wraps mod 2^WIDTH), rcvd++.
// - Compare fail: mismatch_cnt++ (saturating). First fail only: first_bad_idx=rcvd, first_bad_data=rd_data.
// - done=1 for exactly the cycle state==DONE.
// - mismatch_cnt and first_bad_* hold their values until the next accepted start.
// - start during busy is ignored.
// - empty rising mid-run: rd_en drops the same cycle; the in-flight word is still checked.
// - Throughput: back-to-back pops, 1 word/cycle while ~empty.
// - Latency: done = 2 cycles after the cycle of the last rd_en.
// CONFIGURATION
// - `FIFO_RD_TIMEOUT_EN` defined:
//   - stall counter increments each READ cycle with empty=1 and v_q=0, clears otherwise.
//   - on reaching TO_CYCLES: READ->DONE, timeout=1, done pulses; cleared by next accepted start or reset.
// - Undefined: no stall counter, no timeout port. READ waits for data indefinitely.
// TESTING
// - T1 full drain: preload 16 words 0,2,..,30; start, count=16, exp_base=0 -> 16 consecutive rd_en; done 2 cycles after last rd_en; mismatch_cnt=0.
// - T2 empty stall: count=5 with FIFO holding 3 words -> rd_en never high while empty=1.
//   - Writer then adds 2 words -> done, mismatch_cnt=0, FIFO rd_error never asserted.
// - T3 corruption: words 0,2,9,6,8, count=5 -> mismatch_cnt=1, first_bad_idx=2, first_bad_data=9.
// - T4 wrap/zero: exp_base=254, STEP=2, data 254,0,2 -> mismatch_cnt=0.
//   - count=0 -> done one cycle after start; rd_en stays 0.
// - T5 reset mid-run: rst=0 after 4 of 10 reads -> rd_en=0 at once, all outputs 0, no done.
//   - Next start runs cleanly.
// - T6 (macro on): count=3, FIFO empty for TO_CYCLES=64 cycles -> done, timeout=1.
//   - Next start clears timeout.

Source files
------------

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: FIFO read-side consumer that pops a word count and checks
// each word against an arithmetic pattern. `FIFO_RD_TIMEOUT_EN adds a stall watchdog.
module fifo_rd_drain #(
    parameter int WIDTH     = 8,
    parameter int CNT_W     = 16,
    parameter int STEP      = 2,
    parameter int TO_CYCLES = 64
) (
    input  logic             rd_clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] exp_base,
    input  logic             empty,
    input  logic [WIDTH-1:0] rd_data,
    output logic             rd_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_bad_idx,
`ifdef FIFO_RD_TIMEOUT_EN
    output logic [WIDTH-1:0] first_bad_data,
    output logic             timeout
`else
    output logic [WIDTH-1:0] first_bad_data
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DONE
    } state_t;

    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (TO_CYCLES < 1) begin : g_to_check
        $error("TO_CYCLES must be at least 1");
    end

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] rcvd;
    logic [CNT_W-1:0] rcvd_nxt;
    logic [WIDTH-1:0] exp_q;
    logic             v_q;
    logic             bad;
    logic             accept;

    assign accept   = (state == IDLE) && start;
    assign bad      = v_q && (rd_data != exp_q);
    assign rcvd_nxt = rcvd + {{(CNT_W-1){1'b0}}, v_q};

`ifdef FIFO_RD_TIMEOUT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic             stall;
    logic             to_hit;

    assign stall  = (state == READ) && empty && !v_q;
    assign to_hit = stall && (stall_cnt == CNT_W'(TO_CYCLES - 1));
`endif

    // State register; reset aborts any run at once.
    always_ff @(posedge rd_clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; finish as soon as the last word lands.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (count == '0) ? DONE : READ;
                end
            end
            READ: begin
                busy  = 1'b1;
                rd_en = !empty && (issued != count_q);
                if (rcvd_nxt == count_q) begin
                    state_nxt = DONE;
                end
`ifdef FIFO_RD_TIMEOUT_EN
                else if (to_hit) begin
                    state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters, expected-pattern tracker and mismatch bookkeeping.
    always_ff @(posedge rd_clk or negedge rst) begin
        if (!rst) begin
            count_q        <= '0;
            issued         <= '0;
            rcvd           <= '0;
            exp_q          <= '0;
            v_q            <= 1'b0;
            mismatch_cnt   <= '0;
            first_bad_idx  <= '0;
            first_bad_data <= '0;
        end else begin
            v_q <= rd_en;
            if (accept) begin
                count_q        <= count;
                exp_q          <= exp_base;
                issued         <= '0;
                rcvd           <= '0;
                mismatch_cnt   <= '0;
                first_bad_idx  <= '0;
                first_bad_data <= '0;
            end else begin
                if (rd_en) begin
                    issued <= issued + 1'b1;
                end
                if (v_q) begin
                    exp_q <= exp_q + STEP_W;
                    rcvd  <= rcvd_nxt;
                end
                if (bad) begin
                    if (mismatch_cnt == '0) begin
                        first_bad_idx  <= rcvd;
                        first_bad_data <= rd_data;
                    end
                    if (mismatch_cnt != CNT_MAX) begin
                        mismatch_cnt <= mismatch_cnt + 1'b1;
                    end
                end
            end
        end
    end

`ifdef FIFO_RD_TIMEOUT_EN
    // Empty-stall watchdog; timeout stays set until the next run starts.
    always_ff @(posedge rd_clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end else if (accept) begin
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            if (stall) begin
                stall_cnt <= stall_cnt + 1'b1;
            end else begin
                stall_cnt <= '0;
            end
            if (to_hit) begin
                timeout <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb_fifo_rd_drain: directed runs against a FIFO model plus a per-cycle
// behavioural scoreboard of rd_en/busy/done and the run results.
module tb_fifo_rd_drain;

    localparam int WIDTH     = 8;
    localparam int CNT_W     = 16;
    localparam int STEP      = 2;
    localparam int TO_CYCLES = 64;

    logic             rd_clk   = 1'b0;
    logic             rst      = 1'b0;
    logic             start    = 1'b0;
    logic [CNT_W-1:0] count    = '0;
    logic [WIDTH-1:0] exp_base = '0;
    logic             empty;
    logic [WIDTH-1:0] rd_data  = '0;
    logic             rd_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [CNT_W-1:0] first_bad_idx;
    logic [WIDTH-1:0] first_bad_data;
`ifdef FIFO_RD_TIMEOUT_EN
    logic             timeout;
`endif

    fifo_rd_drain #(
        .WIDTH(WIDTH), .CNT_W(CNT_W), .STEP(STEP), .TO_CYCLES(TO_CYCLES)
    ) dut (
        .rd_clk(rd_clk),
        .rst(rst),
        .start(start),
        .count(count),
        .exp_base(exp_base),
        .empty(empty),
        .rd_data(rd_data),
        .rd_en(rd_en),
        .busy(busy),
        .done(done),
        .mismatch_cnt(mismatch_cnt),
        .first_bad_idx(first_bad_idx),
`ifdef FIFO_RD_TIMEOUT_EN
        .timeout(timeout),
`endif
        .first_bad_data(first_bad_data)
    );

    always #5 rd_clk = ~rd_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // FIFO model: registered read data, underflow counted.
    logic [WIDTH-1:0] mem [0:255];
    int wp = 0;
    int rp = 0;
    int rd_err = 0;
    assign empty = (wp == rp);

    always @(posedge rd_clk) begin
        if (rd_en) begin
            if (wp == rp) begin
                rd_err <= rd_err + 1;
            end else begin
                rd_data <= mem[rp % 256];
                rp      <= rp + 1;
            end
        end
    end

    task automatic push(input int d);
        mem[wp % 256] = WIDTH'(d);
        wp = wp + 1;
    endtask

    // Scoreboard state.
    int  cyc = 0;
    bit  m_read = 0;
    int  m_done_at = -1;
    int  m_cnt = 0;
    int  m_issued = 0;
    int  m_base = 0;
    int  m_rp0 = 0;
    bit  m_inflight = 0;
    int  m_stall = 0;
    bit  m_timeout = 0;
    bit  exp_read, exp_rd, exp_done;
    int  mc, fi, fd, e;
    int  rd_cnt = 0, first_rd = 0, last_rd = 0;
    int  done_cyc = 0, start_cyc = 0;
    bit  done_seen = 0;

    always @(negedge rd_clk) begin
        cyc++;
        if (!rst) begin
            m_read     = 0;
            m_done_at  = -1;
            m_inflight = 0;
            m_stall    = 0;
            m_timeout  = 0;
            chk("rst_rd_en", rd_en, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_mm", mismatch_cnt, 0);
        end else begin
            exp_read = m_read && (m_done_at < 0 || cyc < m_done_at);
            exp_rd   = exp_read && !empty && (m_issued != m_cnt);
            exp_done = (cyc == m_done_at);
            chk("rd_en", rd_en, exp_rd);
            chk("done", done, exp_done);
            chk("busy", busy, exp_read || exp_done);
`ifdef FIFO_RD_TIMEOUT_EN
            chk("timeout", timeout, m_timeout);
`endif
            if (exp_done) begin
                mc = 0; fi = 0; fd = 0;
                for (int k = 0; k < m_issued; k++) begin
                    e = (m_base + k * STEP) % 256;
                    if (int'(mem[(m_rp0 + k) % 256]) != e) begin
                        if (mc == 0) begin
                            fi = k;
                            fd = int'(mem[(m_rp0 + k) % 256]);
                        end
                        mc++;
                    end
                end
                chk("res_mm", mismatch_cnt, mc);
                chk("res_idx", first_bad_idx, fi);
                chk("res_data", first_bad_data, fd);
            end
            if (rd_en) begin
                rd_cnt++;
                if (rd_cnt == 1) first_rd = cyc;
                last_rd = cyc;
            end
            if (done) begin
                done_cyc  = cyc;
                done_seen = 1;
            end
            if (exp_rd) begin
                m_issued++;
                if (m_issued == m_cnt) m_done_at = cyc + 2;
            end
`ifdef FIFO_RD_TIMEOUT_EN
            if (exp_read && m_done_at < 0) begin
                if (empty && !m_inflight) begin
                    m_stall++;
                    if (m_stall == TO_CYCLES) begin
                        m_done_at = cyc + 1;
                        m_timeout = 1;
                    end
                end else begin
                    m_stall = 0;
                end
            end
`endif
            m_inflight = exp_rd;
            if (exp_done) begin
                m_read    = 0;
                m_done_at = -1;
            end
            if (!exp_read && !exp_done && start) begin
                m_cnt     = int'(count);
                m_base    = int'(exp_base);
                m_rp0     = rp;
                m_issued  = 0;
                m_stall   = 0;
                m_timeout = 0;
                rd_cnt    = 0;
                done_seen = 0;
                start_cyc = cyc;
                if (count == '0) begin
                    m_read    = 0;
                    m_done_at = cyc + 1;
                end else begin
                    m_read    = 1;
                    m_done_at = -1;
                end
            end
        end
    end

    task automatic pulse_start(input int n, input int base);
        @(posedge rd_clk);
        #2;
        start    = 1'b1;
        count    = CNT_W'(n);
        exp_base = WIDTH'(base);
        @(posedge rd_clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge rd_clk);
            #1;
            if (done_seen) begin
                ok = 1;
                break;
            end
        end
        chk("done_wait", ok, 1);
    endtask

    initial begin
        repeat (3) @(posedge rd_clk);
        #1;
        chk("reset_rd_en", rd_en, 0);
        chk("reset_first_idx", first_bad_idx, 0);
        chk("reset_first_data", first_bad_data, 0);
        @(posedge rd_clk);
        #2;
        rst = 1'b1;

        // T1: full drain of 16 words, with a start pulse ignored mid-run.
        for (int i = 0; i < 16; i++) push(i * 2);
        pulse_start(16, 0);
        repeat (4) @(posedge rd_clk);
        #2;
        start = 1'b1; count = 16'd3; exp_base = 8'd100;
        @(posedge rd_clk);
        #2;
        start = 1'b0;
        wait_done(100);
        chk("t1_rd_cnt", rd_cnt, 16);
        chk("t1_consec", last_rd - first_rd, 15);
        chk("t1_latency", done_cyc - last_rd, 2);
        chk("t1_mm", mismatch_cnt, 0);

        // T2: FIFO short of words, writer tops it up later.
        push(32); push(34); push(36);
        pulse_start(5, 32);
        repeat (10) @(posedge rd_clk);
        #2;
        chk("t2_busy_stalled", busy, 1);
        push(38); push(40);
        wait_done(100);
        chk("t2_rd_cnt", rd_cnt, 5);
        chk("t2_mm", mismatch_cnt, 0);
        chk("t2_rd_err", rd_err, 0);

        // T3: one corrupted word.
        push(0); push(2); push(9); push(6); push(8);
        pulse_start(5, 0);
        wait_done(100);
        chk("t3_mm", mismatch_cnt, 1);
        chk("t3_idx", first_bad_idx, 2);
        chk("t3_data", first_bad_data, 9);

        // T4: pattern wrap, then a zero-length run.
        push(254); push(0); push(2);
        pulse_start(3, 254);
        wait_done(100);
        chk("t4_mm", mismatch_cnt, 0);
        pulse_start(0, 0);
        wait_done(20);
        chk("t4_zero_lat", done_cyc - start_cyc, 1);
        chk("t4_zero_rd", rd_cnt, 0);
        chk("t4_zero_mm", mismatch_cnt, 0);

        // T5: reset after 4 of 10 reads, then a clean follow-up run.
        push(0); push(2); push(5); push(6); push(8);
        push(10); push(12); push(14); push(16); push(18);
        pulse_start(10, 0);
        begin
            bit ok = 0;
            for (int i = 0; i < 50; i++) begin
                @(posedge rd_clk);
                #1;
                if (rd_cnt >= 4) begin
                    ok = 1;
                    break;
                end
            end
            chk("t5_reach4", ok, 1);
        end
        chk("t5_pre_mm", mismatch_cnt, 1);
        #1;
        rst = 1'b0;
        #1;
        chk("t5_rd_en", rd_en, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_mm", mismatch_cnt, 0);
        chk("t5_idx", first_bad_idx, 0);
        chk("t5_data", first_bad_data, 0);
        repeat (2) @(posedge rd_clk);
        chk("t5_no_done", done_seen, 0);
        #2;
        rst = 1'b1;
        pulse_start(6, 8);
        wait_done(100);
        chk("t5_rerun_rd", rd_cnt, 6);
        chk("t5_rerun_mm", mismatch_cnt, 0);
        chk("t5_rd_err", rd_err, 0);

`ifdef FIFO_RD_TIMEOUT_EN
        // T6: starved run trips the watchdog; next run clears it.
        pulse_start(3, 0);
        wait_done(TO_CYCLES + 20);
        chk("t6_timeout", timeout, 1);
        chk("t6_rd_cnt", rd_cnt, 0);
        push(0); push(2); push(4);
        pulse_start(3, 0);
        wait_done(100);
        chk("t6_cleared", timeout, 0);
        chk("t6_mm", mismatch_cnt, 0);
`endif

        repeat (3) @(posedge rd_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
